// File: rtl/pack.sv
// Calorimeter tower packer: accumulates a 32x32 (eta, phi) grid and streams occupied towers on start.
// Define PACK_ZS_EN to emit only towers whose et reaches the threshold latched at start.
module pack #(
    parameter int unsigned ETA_W = 5,
    parameter int unsigned PHI_W = 5,
    parameter int unsigned VAL_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ETA_W-1:0]       wr_eta,
    input  logic [PHI_W-1:0]       wr_phi,
    input  logic [VAL_W-1:0]       wr_et,
    input  logic [VAL_W-1:0]       wr_e,
    output logic                   wr_drop,
    input  logic                   start,
    input  logic [VAL_W-1:0]       thresh,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ETA_W-1:0]       out_eta,
    output logic [PHI_W-1:0]       out_phi,
    output logic [VAL_W-1:0]       out_et,
    output logic [VAL_W-1:0]       out_e,
    output logic                   busy,
    output logic                   done,
    output logic [ETA_W+PHI_W:0]   hit_count
);

    localparam int unsigned ADDR_W = ETA_W + PHI_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {StIdle, StRead, StCheck, StEmit, StFin} state_t;

    state_t                 state;
    logic [ADDR_W-1:0]      idx;
    logic [ADDR_W-1:0]      wr_addr;
    logic                   wr_ok;
    logic [DEPTH-1:0]       occ;
    logic [2*VAL_W-1:0]     ram [DEPTH];
    logic [2*VAL_W-1:0]     rd_data;
    logic [VAL_W-1:0]       rd_et;
    logic [VAL_W-1:0]       rd_e;
    logic                   qualify;

    // Phi-major addressing: idx = eta + phi * 32.
    assign wr_addr = {wr_phi, wr_eta};
    assign wr_ok   = wr_en && (state == StIdle);
    assign rd_et   = rd_data[2*VAL_W-1:VAL_W];
    assign rd_e    = rd_data[VAL_W-1:0];

    // Tower RAM is deliberately not reset; occ alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ram[wr_addr] <= {wr_et, wr_e};
        end
        if (state == StRead) begin
            rd_data <= ram[idx];
        end
    end

`ifdef PACK_ZS_EN
    logic [VAL_W-1:0] thresh_lat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thresh_lat <= '0;
        end else if (state == StIdle && start) begin
            thresh_lat <= thresh;
        end
    end

    assign qualify = occ[idx] && (rd_et >= thresh_lat);
`else
    logic unused_thresh;

    assign unused_thresh = ^thresh;
    assign qualify       = occ[idx];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            idx       <= '0;
            occ       <= '0;
            out_valid <= 1'b0;
            out_eta   <= '0;
            out_phi   <= '0;
            out_et    <= '0;
            out_e     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_drop   <= 1'b0;
            hit_count <= '0;
        end else begin
            done    <= 1'b0;
            wr_drop <= wr_en && (state != StIdle);
            if (wr_ok) begin
                occ[wr_addr] <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (start) begin
                        idx       <= '0;
                        hit_count <= '0;
                        busy      <= 1'b1;
                        state     <= StRead;
                    end
                end
                StRead: begin
                    state <= StCheck;
                end
                StCheck: begin
                    if (qualify) begin
                        out_valid <= 1'b1;
                        out_eta   <= idx[ETA_W-1:0];
                        out_phi   <= idx[ADDR_W-1:ETA_W];
                        out_et    <= rd_et;
                        out_e     <= rd_e;
                        state     <= StEmit;
                    end else if (&idx) begin
                        done  <= 1'b1;
                        state <= StFin;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= StRead;
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        hit_count <= hit_count + 1'b1;
                        occ[idx]  <= 1'b0;
                        if (&idx) begin
                            done  <= 1'b1;
                            state <= StFin;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= StRead;
                        end
                    end
                end
                StFin: begin
                    occ   <= '0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pack.sv
// Scoreboard bench for pack: a grid model predicts each scan's word list, a monitor checks the stream.
module tb_pack;

    localparam int ETA_W = 5;
    localparam int PHI_W = 5;
    localparam int VAL_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic [4:0]       wr_eta = '0;
    logic [4:0]       wr_phi = '0;
    logic [9:0]       wr_et = '0;
    logic [9:0]       wr_e = '0;
    logic             wr_drop;
    logic             start = 1'b0;
    logic [9:0]       thresh = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4:0]       out_eta;
    logic [4:0]       out_phi;
    logic [9:0]       out_et;
    logic [9:0]       out_e;
    logic             busy;
    logic             done;
    logic [10:0]      hit_count;

    pack #(.ETA_W(ETA_W), .PHI_W(PHI_W), .VAL_W(VAL_W)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_eta(wr_eta), .wr_phi(wr_phi), .wr_et(wr_et), .wr_e(wr_e),
        .wr_drop(wr_drop), .start(start), .thresh(thresh),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_eta(out_eta), .out_phi(out_phi), .out_et(out_et), .out_e(out_e),
        .busy(busy), .done(done), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] eta;
        logic [4:0] phi;
        logic [9:0] et;
        logic [9:0] e;
    } word_t;

    int    checks = 0;
    int    failures = 0;
    word_t exp_q[$];
    int    m_et[1024];
    int    m_e[1024];
    bit    m_occ[1024];
    int    ready_mode = 0;  // 0: always ready, 1: random, 2: held low
    bit    mon_en = 1'b1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: a handshake seen at a falling edge completes on the next rising edge.
    word_t held;
    bit    held_v = 1'b0;
    always @(negedge clk) begin
        word_t cur;
        cur = {out_eta, out_phi, out_et, out_e};
        if (!mon_en) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("valid_held", longint'(out_valid), 1);
                check("fields_held", longint'(cur), longint'(held));
            end
            held_v = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got eta=%0d phi=%0d et=%0d e=%0d, expected none",
                             out_eta, out_phi, out_et, out_e);
                end else begin
                    check("word", longint'(cur), longint'(exp_q.pop_front()));
                end
            end else if (out_valid) begin
                held_v = 1'b1;
                held = cur;
            end
        end
    end

    function automatic bit qualifies(input int et, input int th);
`ifdef PACK_ZS_EN
        return et >= th;
`else
        return 1'b1;
`endif
    endfunction

    // Predict a scan: every occupied qualifying tower in ascending index, then the grid empties.
    function automatic int build_expect(input int th);
        int n = 0;
        for (int i = 0; i < 1024; i++) begin
            if (m_occ[i] && qualifies(m_et[i], th)) begin
                word_t w;
                w.eta = 5'(i % 32);
                w.phi = 5'(i / 32);
                w.et  = 10'(m_et[i]);
                w.e   = 10'(m_e[i]);
                exp_q.push_back(w);
                n++;
            end
            m_occ[i] = 1'b0;
        end
        return n;
    endfunction

    task automatic drive_write(input int idx, input int et, input int e);
        wr_en  = 1'b1;
        wr_eta = 5'(idx % 32);
        wr_phi = 5'(idx / 32);
        wr_et  = 10'(et);
        wr_e   = 10'(e);
    endtask

    task automatic write_tower(input int idx, input int et, input int e);
        drive_write(idx, et, e);
        m_occ[idx] = 1'b1;
        m_et[idx]  = et;
        m_e[idx]   = e;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic run_scan(input string tag, input int th, input int stall, input bit poke,
                            input bit co_write, input int exp_first, output int n_exp);
        int  cyc = 0;
        int  first_v = -1;
        int  stall_cnt = 0;
        bit  timing = (ready_mode == 0) && (stall == 0);
        bit  seen_done = 1'b0;
        if (stall > 0) ready_mode = 2;
        if (co_write) begin
            int et = int'($urandom_range(0, 1023));
            drive_write(700, et, 321);
            m_occ[700] = 1'b1;
            m_et[700]  = et;
            m_e[700]   = 321;
        end
        start  = 1'b1;
        thresh = 10'(th);
        n_exp  = build_expect(th);
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        while (!seen_done && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "_busy_rise"}, longint'(busy), 1);
            if (out_valid && first_v < 0) first_v = cyc;
            if (stall > 0 && out_valid && stall_cnt < stall) begin
                stall_cnt++;
                if (stall_cnt == stall) ready_mode = 0;
            end
            if (poke && cyc == 100) begin
                drive_write(500, 900, 77);
                start = 1'b1;
            end
            if (poke && cyc == 101) begin
                check({tag, "_wr_drop_pulse"}, longint'(wr_drop), 1);
                wr_en = 1'b0;
                start = 1'b0;
            end
            if (poke && cyc == 102) check({tag, "_wr_drop_clear"}, longint'(wr_drop), 0);
            if (done) seen_done = 1'b1;
        end
        if (!seen_done) begin
            checks++;
            failures++;
            $display("FAIL %s_done_timeout: got no done after %0d cycles, expected done", tag, cyc);
        end else begin
            if (timing) check({tag, "_done_cycle"}, cyc, 2049 + n_exp);
            if (exp_first >= 0) check({tag, "_first_valid_cycle"}, first_v, exp_first);
            check({tag, "_hit_count"}, longint'(hit_count), n_exp);
            check({tag, "_queue_drained"}, exp_q.size(), 0);
            @(negedge clk);
            check({tag, "_done_pulse"}, longint'(done), 0);
            check({tag, "_busy_fall"}, longint'(busy), 0);
        end
        exp_q.delete();
        ready_mode = 0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) m_occ[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_wr_drop", longint'(wr_drop), 0);
        check("rst_hit_count", longint'(hit_count), 0);
        check("rst_fields", longint'({out_eta, out_phi, out_et, out_e}), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single tower (eta 3, phi 2) = idx 67: first valid at 3 + 2*67.
        write_tower(3 + 2 * 32, 100, 200);
        run_scan("single", 0, 0, 1'b0, 1'b0, 137, n);

        // Ordering and far corner, then grid must be empty.
        write_tower(1023, 1000, 11);
        write_tower(40, 600, 22);
        write_tower(5, 300, 33);
        run_scan("order", 0, 0, 1'b0, 1'b0, 3 + 2 * 5, n);
        check("order_count", n, 3);
        run_scan("empty", 0, 0, 1'b0, 1'b0, -1, n);
        check("empty_hits", longint'(hit_count), 0);

        // Threshold boundary.
        write_tower(100, 49, 1);
        write_tower(101, 50, 2);
        write_tower(102, 51, 3);
        run_scan("thresh", 50, 0, 1'b0, 1'b0, -1, n);
`ifdef PACK_ZS_EN
        check("thresh_hits", longint'(hit_count), 2);
`else
        check("thresh_hits", longint'(hit_count), 3);
`endif

        // Backpressure on the first word, plus a write and start landing together.
        write_tower(10, 800, 44);
        write_tower(20, 810, 55);
        run_scan("stall", 0, 10, 1'b0, 1'b1, -1, n);

        // Writes and starts during a scan are refused; the dropped tower never appears.
        write_tower(300, 700, 66);
        run_scan("poke", 0, 0, 1'b1, 1'b0, -1, n);
        run_scan("after_poke", 0, 0, 1'b0, 1'b0, -1, n);

        // Randomized grids with random backpressure and threshold.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 30; k++) begin
                write_tower(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                            int'($urandom_range(0, 1023)));
            end
            write_tower(0, int'($urandom_range(0, 1023)), 5);
            write_tower(1023, int'($urandom_range(0, 1023)), 6);
            ready_mode = 1;
            run_scan("random", int'($urandom_range(0, 1023)), 0, 1'b0, 1'b0, -1, n);
        end

        // Reset while a word is waiting.
        write_tower(2, 123, 456);
        m_occ[2] = 1'b0;
        mon_en = 1'b0;
        ready_mode = 2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            int w = 0;
            while (!out_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
            check("rst_emit_reached", longint'(out_valid), 1);
        end
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_valid", longint'(out_valid), 0);
        check("rst_mid_busy", longint'(busy), 0);
        check("rst_mid_hits", longint'(hit_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ready_mode = 0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        run_scan("post_reset", 0, 0, 1'b0, 1'b0, -1, n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
